// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed common-anode 7-segment driver.
// Display inputs are snapshotted once per frame; all outputs are registered.
module seven_seg_scan #(
  parameter int unsigned DIV          = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        blank_lz,
  input  logic        blink,
  input  logic [3:0]  dp_sel,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   val_q;
  logic          blz_q, blink_q;
  logic [3:0]    dpsel_q;
  logic [FW-1:0] frm_q, frm_d;
  logic          phase_q, phase_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          fs_q;

  logic          wrap_c, capture_c, blanked_c, off_c;
  logic [3:0]    nib_c;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign wrap_c    = (tick_q == TICK_LAST);
  assign capture_c = wrap_c && (idx_q == 2'd3);

  // Slot timing: tick wraps every DIV cycles and steps the digit index
  always_comb begin
    tick_d = tick_q + 1'b1;
    idx_d  = idx_q;
    if (wrap_c) begin
      tick_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  // Blink phase advances per captured frame, held clear while blink is off
  always_comb begin
    frm_d   = frm_q;
    phase_d = phase_q;
    if (!blink_q) begin
      frm_d   = '0;
      phase_d = 1'b0;
    end else if (capture_c) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // Render the current digit from the frame snapshot
  always_comb begin
    nib_c = 4'(val_q >> {idx_q, 2'b00});
    case (idx_q)
      2'd1:    blanked_c = blz_q && (val_q[15:4] == 12'h000);
      2'd2:    blanked_c = blz_q && (val_q[15:8] == 8'h00);
      2'd3:    blanked_c = blz_q && (val_q[15:12] == 4'h0);
      default: blanked_c = 1'b0;
    endcase
    off_c = blanked_c || (blink_q && phase_q);
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!off_c) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = hex7(nib_c);
      dp_d  = ~dpsel_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= TICK_LAST;
      idx_q   <= 2'd3;
      val_q   <= '0;
      blz_q   <= 1'b0;
      blink_q <= 1'b0;
      dpsel_q <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= capture_c;
      if (capture_c) begin
        val_q   <= value;
        blz_q   <= blank_lz;
        blink_q <= blink;
        dpsel_q <= dp_sel;
      end
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: directed test-plan scenarios followed
// by random input churn, all compared against a frame-level behavioural model.
module tb_seven_seg_scan;

  localparam int DIV   = 4;
  localparam int BF    = 2;
  localparam int FRAME = 4 * DIV;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic        blank_lz;
  logic        blink;
  logic [3:0]  dp_sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  seven_seg_scan #(.DIV(DIV), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .blank_lz    (blank_lz),
    .blink       (blink),
    .dp_sel      (dp_sel),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges since reset release, frame snapshot, blink-run length
  int          m_cnt;
  logic [15:0] s_val;
  logic        s_blz;
  logic        s_blink;
  logic [3:0]  s_dp;
  int          m_fb;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic int cur_digit();
    return (m_cnt == 0) ? 3 : ((m_cnt - 1) / DIV) % 4;
  endfunction

  // One clock: predict outputs from the pre-edge model, update model, compare
  task automatic cyc();
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic        e_fs;
    logic [15:0] sh;
    int          d;
    bit          off;
    @(posedge clk);
    e_an  = 4'hF;
    e_seg = 7'h7F;
    e_dp  = 1'b1;
    e_fs  = 1'b0;
    if (rst) begin
      m_cnt   = 0;
      s_val   = '0;
      s_blz   = 1'b0;
      s_blink = 1'b0;
      s_dp    = '0;
      m_fb    = 0;
    end else begin
      d   = cur_digit();
      sh  = s_val >> (4 * d);
      off = (s_blz && d != 0 && sh == 16'h0) ||
            (s_blink && (((m_fb - 1) / BF) % 2) == 1);
      if (!off) begin
        e_an  = ~(4'(1) << d);
        e_seg = hex_tbl[sh[3:0]];
        e_dp  = ~s_dp[d];
      end
      if (m_cnt % FRAME == 0) begin
        e_fs    = 1'b1;
        s_val   = value;
        s_blz   = blank_lz;
        s_blink = blink;
        s_dp    = dp_sel;
        m_fb    = blink ? m_fb + 1 : 0;
      end
      m_cnt++;
    end
    #1;
    check_eq("an", 16'(an), 16'(e_an));
    check_eq("seg", 16'(seg), 16'(e_seg));
    check_eq("dp", 16'(dp), 16'(e_dp));
    check_eq("frame_start", 16'(frame_start), 16'(e_fs));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Advance until the model says digit d is currently being scanned
  task automatic run_to_digit(input int d);
    int guard;
    guard = 0;
    while (!(m_cnt != 0 && cur_digit() == d && ((m_cnt - 1) % DIV) == 1) && guard < 2 * FRAME) begin
      cyc();
      guard++;
    end
    check_eq("digit_align_timeout", 16'(guard < 2 * FRAME), 16'd1);
  endtask

  initial begin
    rst      = 1'b1;
    value    = '0;
    blank_lz = 1'b0;
    blink    = 1'b0;
    dp_sel   = '0;
    m_cnt    = 0;
    s_val    = '0;
    s_blz    = 1'b0;
    s_blink  = 1'b0;
    s_dp     = '0;
    m_fb     = 0;
    run(2);

    // Plain hex rendering
    rst   = 1'b0;
    value = 16'h12AF;
    run(2 * FRAME);

    // Leading-zero blanking
    value    = 16'h0042;
    blank_lz = 1'b1;
    run(2 * FRAME);
    value = 16'h0000;
    run(2 * FRAME);
    blank_lz = 1'b0;

    // Mid-frame change is deferred to the next capture
    value = 16'h1111;
    run(FRAME);
    run_to_digit(1);
    value = 16'h2222;
    run(2 * FRAME);

    // Whole-display blink, then steady again
    value = 16'h8888;
    blink = 1'b1;
    run_to_digit(0);
    run(7 * FRAME);
    blink = 1'b0;
    run(2 * FRAME);

    // Decimal point on digit 2
    dp_sel = 4'b0100;
    run(2 * FRAME);
    dp_sel = 4'b0000;

    // Mid-frame reset
    run_to_digit(2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run(2 * FRAME);

    // Random churn of all display inputs with occasional resets
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0)   value    = 16'($urandom);
      if ($urandom_range(0, 31) == 0)  blank_lz = 1'($urandom);
      if ($urandom_range(0, 199) == 0) blink    = ~blink;
      if ($urandom_range(0, 15) == 0)  dp_sel   = 4'($urandom);
      if ($urandom_range(0, 4) == 0 && value[15:8] != 8'h00) value[15:8] = 8'h00;
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end
    rst = 1'b0;
    run(FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

- Multiplexed 4-digit, common-anode 7-segment driver for the vending machine's display path.
- Consumes the 16-bit display word selected upstream (code, money or refund) and renders it as 4 hex digits, refreshing one digit at a time.
- Inputs are captured once per frame, so a digit never shows a mix of old and new values.
- Adds leading-zero blanking, per-digit decimal points and whole-display blinking.

## Interface

Parameters:
- `DIV`, default 100000: clock cycles per digit slot (1 ms at 100 MHz). Legal range ≥ 2.
- `BLINK_FRAMES`, default 125: frames per blink half-period (0.5 s at defaults). Legal range ≥ 1.

Ports:
- `clk`  in  1  — single system clock; all logic on rising edge.
- `rst`  in  1  — synchronous reset, active-high.
- `value`  in  16  — display word; `value[3:0]` = digit 0 (rightmost), `value[15:12]` = digit 3.
- `blank_lz`  in  1  — 1 = blank leading zero digits.
- `blink`  in  1  — 1 = flash the whole display.
- `dp_sel`  in  4  — decimal point request per digit, active-high; bit k → digit k.
- `an`  out  4  — anode enables, active-low; bit k → digit k.
- `seg`  out  7  — segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp`  out  1  — decimal point segment, active-low.
- `frame_start`  out  1  — one-cycle pulse marking the frame capture edge.

## Operation

Tick counter:
- `tick` counts 0..DIV-1 and wraps.
- Digit index `idx` (2 bits) advances 0→1→2→3→0 on each wrap of `tick`.
- Frame = 4·DIV cycles.

Frame capture:
- Occurs on the edge where `tick` wraps while `idx`=3.
- On that edge: shadow ← `value`; shadow copies of `blank_lz`, `blink`, `dp_sel` updated; `frame_start` ← 1 (0 on all other edges).
- All rendering uses the shadow copies only.

Blink:
- Frame counter counts 0..BLINK_FRAMES-1 at each capture; on wrap it toggles `phase`.
- When shadow `blink`=0: `phase` and the frame counter are held at 0.
- When shadow `blink`=1 and `phase`=1: `an`=4'b1111 for the whole frame.

Leading-zero blanking:
- Digit k (k=1..3) is blanked when shadow `blank_lz`=1 and shadow nibbles k..3 are all 0.
- Digit 0 is never blanked.

Rendering (registered from current state each cycle):
- `an` = all ones except bit `idx` = 0, unless the digit is blanked or in blink-off, in which case `an`=4'b1111.
- `seg` = hex decode of shadow nibble `idx`, as {g..a} active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- `dp` = ~shadow `dp_sel[idx]`.
- When `an`=4'b1111, `seg` and `dp` are driven to all ones.

Reset (`rst`=1 at an edge):
- Registers: `tick`=DIV-1, `idx`=3, shadows 0, frame counter 0, `phase` 0.
- Outputs: `an`=4'b1111, `seg`=7'h7F, `dp`=1, `frame_start`=0.
- Reset mid-frame aborts the frame immediately; there is no partial state.

## Timing

- The first non-reset edge after `rst` falls is a capture edge: `frame_start`=1 and shadow loaded.
- The next edge drives digit 0 on the outputs.
- Output latency: `an`/`seg`/`dp` reflect (`idx`, shadow) of the previous cycle, i.e. they lag the capture edge by exactly 1 cycle.
- Digit slot length is exactly DIV cycles; frame start to frame start is 4·DIV cycles, with no gaps.
- Changes to `value`, `blank_lz`, `blink` or `dp_sel` between capture edges have no visible effect until the next capture.
  - A change coincident with the capture edge is captured.
- Blink half-period = BLINK_FRAMES frames.
  - When `blink` is captured as 1 with `phase`=0, the display is visible for the first BLINK_FRAMES frames.
- Segment code for hex digits (A–F) is always rendered; no BCD restriction.

## Test plan

Bench parameters: DIV=4, BLINK_FRAMES=2 (frame = 16 cycles).

1. Reset, `value`=16'h12AF, no options.
   - `frame_start` on the 1st edge after reset.
   - Then `an` walks 1110, 1101, 1011, 0111, each for 4 cycles.
   - `seg` = 0E, 08, 24, 79 respectively.
2. `value`=16'h0042, `blank_lz`=1.
   - Digits 0,1 show 24 then 19 with `an` 1110 / 1101.
   - Digit 2 and digit 3 slots: `an`=1111.
   - `value`=16'h0000: only digit 0 lit, showing 40.
3. Change `value` from 16'h1111 to 16'h2222 mid-frame while digit 1 is shown.
   - Digits 1–3 still show 79 in that frame.
   - 24 appears only after the next `frame_start`.
4. `blink`=1, `value`=16'h8888.
   - Frames 1–2 lit (`seg`=00).
   - Frames 3–4: `an`=1111, `seg`=7F, `dp`=1.
   - Frames 5–6 lit.
   - `blink`=0 restores steady display from the next frame.
5. `dp_sel`=4'b0100.
   - `dp`=0 only during the digit 2 slot; `dp`=1 elsewhere.
6. Assert `rst` for 1 cycle mid-frame while digit 2 is shown.
   - Next cycle: `an`=1111, `seg`=7F.
   - Capture and `frame_start` on the first edge after release, digit 0 one cycle later.
